// File: rtl/logic_thief_reader_if.sv
// Bus between the logic-thief readout engine, capture BRAM port B and the
// software word handshake. master = readout engine side.
interface logic_thief_reader_if #(
    parameter int DW = 192,
    parameter int AW = 8
);
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_rdata_i;
    logic [31:0]   word_o;
    logic          word_valid_o;
    logic          word_ack_i;

    modport master (output mem_addr_o, word_o, word_valid_o, input mem_rdata_i, word_ack_i);
    modport slave  (input mem_addr_o, word_o, word_valid_o, output mem_rdata_i, word_ack_i);
endinterface

// File: rtl/logic_thief_reader.sv
// Logic-thief capture readout: walks BRAM port B and serves each entry as 32-bit words.
// Optional LT_READ_CHECKSUM_EN appends an XOR checksum word after the last entry.
module logic_thief_reader #(
    parameter int LOGTHIEF_DATA_WIDTH = 192,
    parameter int LOGTHIEF_LOG2_DEEP  = 8,
    parameter int RD_LATENCY          = 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [31:0]                 cmd_i,
    input  logic [LOGTHIEF_LOG2_DEEP:0] num_entries_i,
    output logic [31:0]                 status_o,
    logic_thief_reader_if.master        bus
);
    localparam int AW    = LOGTHIEF_LOG2_DEEP;
    localparam int WORDS = LOGTHIEF_DATA_WIDTH / 32;
    localparam int WIDX  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0] CMD_START = 32'hBEEFBEEF;
    localparam logic [31:0] CMD_ABORT = 32'hDEADDEAD;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SERVE, S_DONE, S_CHK} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          entry_idx_q, entry_idx_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [AW:0]            num_q, num_d;
    logic [WIDX-1:0]        word_idx_q, word_idx_d;
    logic [1:0]             lat_q, lat_d;
    logic [WORDS-1:0][31:0] entry_q, entry_d;
    logic                   aborted_q, aborted_d;
    logic                   start_seen_q;
    logic                   start_hit, abort_hit, start_go, ack_go;
    logic                   chk_ok;
    logic [31:0]            chk_word;
    state_t                 last_state;

    assign start_hit = (cmd_i == CMD_START) && !start_seen_q;
    assign abort_hit = (cmd_i == CMD_ABORT);
    assign start_go  = start_hit && !abort_hit && (state_q == S_IDLE || state_q == S_DONE);
    assign ack_go    = bus.word_ack_i && bus.word_valid_o && !abort_hit;

    always_comb begin
        state_d     = state_q;
        entry_idx_d = entry_idx_q;
        addr_d      = addr_q;
        num_d       = num_q;
        word_idx_d  = word_idx_q;
        lat_d       = lat_q;
        entry_d     = entry_q;
        aborted_d   = aborted_q;
        if (abort_hit) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start_go) begin
                    aborted_d   = 1'b0;
                    num_d       = num_entries_i;
                    entry_idx_d = '0;
                    addr_d      = '0;
                    word_idx_d  = '0;
                    state_d     = (num_entries_i == '0) ? S_DONE : S_FETCH;
                end
                S_FETCH: begin
                    lat_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (lat_q == 2'(RD_LATENCY - 1)) begin
                        entry_d    = bus.mem_rdata_i;
                        word_idx_d = '0;
                        state_d    = S_SERVE;
                    end else begin
                        lat_d = lat_q + 2'd1;
                    end
                end
                S_SERVE: if (ack_go) begin
                    if (word_idx_q != WIDX'(WORDS - 1)) begin
                        word_idx_d = word_idx_q + 1'b1;
                    end else if ({1'b0, entry_idx_q} + 1'b1 == num_q) begin
                        // count compare, so a full-depth read stops at the top address
                        state_d = last_state;
                    end else begin
                        entry_idx_d = entry_idx_q + 1'b1;
                        addr_d      = entry_idx_q + 1'b1;
                        state_d     = S_FETCH;
                    end
                end
                S_CHK: if (ack_go) state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            entry_idx_q  <= '0;
            addr_q       <= '0;
            num_q        <= '0;
            word_idx_q   <= '0;
            lat_q        <= '0;
            entry_q      <= '0;
            aborted_q    <= 1'b0;
            start_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            entry_idx_q  <= entry_idx_d;
            addr_q       <= addr_d;
            num_q        <= num_d;
            word_idx_q   <= word_idx_d;
            lat_q        <= lat_d;
            entry_q      <= entry_d;
            aborted_q    <= aborted_d;
            start_seen_q <= (cmd_i == CMD_START);
        end
    end

`ifdef LT_READ_CHECKSUM_EN
    logic [31:0] chk_q;
    logic        chk_ok_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            chk_q    <= '0;
            chk_ok_q <= 1'b0;
        end else if (start_go) begin
            chk_q    <= '0;
            chk_ok_q <= 1'b0;
        end else if (ack_go && state_q == S_SERVE) begin
            chk_q <= chk_q ^ bus.word_o;
        end else if (ack_go && state_q == S_CHK) begin
            chk_ok_q <= 1'b1;
        end
    end

    assign chk_ok     = chk_ok_q;
    assign chk_word   = chk_q;
    assign last_state = S_CHK;
`else
    assign chk_ok     = 1'b0;
    assign chk_word   = '0;
    assign last_state = S_DONE;
`endif

    assign bus.mem_addr_o   = addr_q;
    assign bus.word_valid_o = (state_q == S_SERVE) || (state_q == S_CHK);
    assign bus.word_o       = (state_q == S_CHK) ? chk_word : entry_q[word_idx_q];

    assign status_o = {(state_q == S_FETCH || state_q == S_WAIT || state_q == S_SERVE || state_q == S_CHK),
                       (state_q == S_DONE), aborted_q, chk_ok, 4'b0,
                       16'(entry_idx_q), 8'(word_idx_q)};
endmodule

// File: tb/tb_logic_thief_reader.sv
// Directed bench for logic_thief_reader with a 1-cycle-latency BRAM model.
module tb_logic_thief_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd;
    logic [8:0]  num;
    logic [31:0] status;
    logic [191:0] mem [256];
    logic [31:0] x;
    logic [191:0] old;
    int errors = 0;
    int checks = 0;
    int busy_cycles;

    logic_thief_reader_if #(.DW(192), .AW(8)) bus ();

    logic_thief_reader #(.LOGTHIEF_DATA_WIDTH(192), .LOGTHIEF_LOG2_DEEP(8), .RD_LATENCY(1)) dut (
        .clk_i(clk), .reset_i(rst), .cmd_i(cmd), .num_entries_i(num), .status_o(status), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) bus.mem_rdata_i <= mem[bus.mem_addr_o];

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int e = 0; e < 256; e++)
            for (int w = 0; w < 6; w++)
                mem[e][32*w +: 32] = {8'h5A, 8'(e), 8'h00, 8'(w + 1)};
    endtask

    task automatic start(input int n);
        num = 9'(n);
        cmd = 32'hBEEFBEEF;
        step();
        cmd = 32'h0;
    endtask

    task automatic readout(input int max_words, output logic [31:0] xs);
        int e = 0, w = 0, words = 0, cyc = 0;
        xs = '0;
        while (words < max_words && cyc < max_words * 4 + 64) begin
            if (bus.word_valid_o) begin
                check("word", bus.word_o, mem[e][32*w +: 32]);
                check("addr", 32'(bus.mem_addr_o), 32'(e));
                check("status_idx", {8'h0, status[23:0]}, {8'h0, 16'(e), 8'(w)});
                xs ^= bus.word_o;
                bus.word_ack_i = 1'b1;
                words++;
                w++;
                if (w == 6) begin
                    w = 0;
                    e++;
                end
            end else begin
                bus.word_ack_i = 1'b0;
            end
            step();
            cyc++;
        end
        bus.word_ack_i = 1'b0;
        check("word_count", 32'(words), 32'(max_words));
    endtask

    task automatic finish_check(input logic [31:0] exp_chk);
`ifdef LT_READ_CHECKSUM_EN
        for (int i = 0; i < 8 && !bus.word_valid_o; i++) step();
        check("chk_valid", 32'(bus.word_valid_o), 32'd1);
        check("chk_word", bus.word_o, exp_chk);
        bus.word_ack_i = 1'b1;
        step();
        bus.word_ack_i = 1'b0;
        check("done_flags", 32'(status[31:28]), 32'b0101);
`else
        check("done_flags", 32'(status[31:28]), 32'b0100);
        check("no_chk_word", 32'(exp_chk === exp_chk), 32'd1);
`endif
        check("done_valid", 32'(bus.word_valid_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cmd = 32'h0;
        num = '0;
        bus.word_ack_i = 1'b0;
        fill_pattern();
        step(3);
        check("rst_status", status, 32'h0);
        check("rst_valid", 32'(bus.word_valid_o), 32'd0);
        check("rst_addr", 32'(bus.mem_addr_o), 32'd0);
        check("rst_word", bus.word_o, 32'h0);
        rst = 1'b0;
        step();

        // two entries, in-order words, then done
        start(2);
        check("t1_busy", 32'(status[31:28]), 32'b1000);
        readout(12, x);
        finish_check(x);

        // zero entries goes straight to done
        start(0);
        check("t2_done", 32'(status[31:28]), 32'b0100);
        check("t2_valid", 32'(bus.word_valid_o), 32'd0);
        step(3);
        check("t2_valid_hold", 32'(bus.word_valid_o), 32'd0);

        // abort mid-entry, then restart from address 0
        start(2);
        readout(3, x);
        cmd = 32'hDEADDEAD;
        step();
        cmd = 32'h0;
        check("t3_valid", 32'(bus.word_valid_o), 32'd0);
        check("t3_flags", 32'(status[31:29]), 32'b001);
        step();
        start(2);
        check("t3_restart_flags", 32'(status[31:29]), 32'b100);
        readout(12, x);
        finish_check(x);

        // start held high: exactly one readout
        num = 9'd1;
        cmd = 32'hBEEFBEEF;
        step();
        readout(6, x);
        finish_check(x);
        busy_cycles = 0;
        for (int i = 0; i < 45; i++) begin
            if (status[31]) busy_cycles++;
            step();
        end
        check("t4_no_restart", 32'(busy_cycles), 32'd0);
        check("t4_done", 32'(status[30]), 32'd1);
        cmd = 32'h0;
        step();

        // full depth
        start(256);
        readout(1536, x);
        check("t5_last_addr", 32'(bus.mem_addr_o), 32'hFF);
        finish_check(x);

        // entry register ignores BRAM changes while serving
        start(1);
        for (int i = 0; i < 10 && !bus.word_valid_o; i++) step();
        check("stable_valid", 32'(bus.word_valid_o), 32'd1);
        old = mem[0];
        mem[0] = ~old;
        step(3);
        check("stable_word", bus.word_o, old[31:0]);
        mem[0] = old;
        cmd = 32'hDEADDEAD;
        step();
        cmd = 32'h0;
        step();

        // reset mid-readout
        start(2);
        readout(8, x);
        rst = 1'b1;
        step();
        check("mid_rst_status", status, 32'h0);
        check("mid_rst_valid", 32'(bus.word_valid_o), 32'd0);
        check("mid_rst_addr", 32'(bus.mem_addr_o), 32'd0);
        check("mid_rst_word", bus.word_o, 32'h0);
        rst = 1'b0;
        step();

`ifdef LT_READ_CHECKSUM_EN
        // all-ones entries, even word count: checksum is zero
        for (int e = 0; e < 256; e++) mem[e] = '1;
        start(2);
        readout(12, x);
        finish_check(32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
